// File: rtl/uart_ack_responder.sv
// UART frame receiver that answers every correctly framed byte with a fixed ACK
// frame after a programmable idle gap (far-end peer for link bring-up).

module uart_ack_responder #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           CLK_FREQ   = 50_000_000,
   parameter int unsigned           BAUD_RATE  = 230400,
   parameter logic [DATA_WIDTH-1:0] ACK_VALUE  = 8'b11001100,
   parameter int unsigned           ACK_DELAY  = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic                  tx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF     = BAUD_DIV / 2;
   localparam int unsigned CNT_MAX  = (BAUD_DIV > ACK_DELAY) ? BAUD_DIV : ACK_DELAY;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_ERR_WAIT,
      S_ACK_WAIT,
      S_ACK_START,
      S_ACK_DATA,
      S_ACK_STOP
   } state_t;

   state_t                r_state;
   logic                  r_meta;
   logic                  r_rxs;
   logic [1:0]            r_fill;
   logic                  r_armed;
   logic [CNT_W-1:0]      r_cnt;
   logic [BIT_W-1:0]      r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_dv;
   logic                  r_fe;
   logic                  r_tx;
   logic                  r_busy;

   state_t                w_state_next;
   logic                  w_fill_done;
   logic                  w_armed_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [BIT_W-1:0]      w_bit_next;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [DATA_WIDTH-1:0] w_data_next;
   logic                  w_dv_next;
   logic                  w_fe_next;
   logic                  w_tx_next;
   logic                  w_busy_next;
   logic                  w_baud_end;

   // rx synchroniser; r_fill marks when r_rxs reflects the real line after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_rxs  <= 1'b1;
         r_fill <= 2'd0;
      end else begin
         r_meta <= rx;
         r_rxs  <= r_meta;
         if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      end
   end

   assign w_fill_done = (r_fill == 2'd2);
   assign w_baud_end  = (r_cnt == CNT_W'(BAUD_DIV - 1));

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_armed <= 1'b0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_dv    <= 1'b0;
         r_fe    <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_armed <= w_armed_next;
         r_cnt   <= w_cnt_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_data  <= w_data_next;
         r_dv    <= w_dv_next;
         r_fe    <= w_fe_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_busy_next;
      end
   end

   // Next-state and next-output logic; tx is computed for the upcoming state
   always_comb begin
      w_state_next = r_state;
      w_armed_next = 1'b0;
      w_cnt_next   = r_cnt + CNT_W'(1);
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_data_next  = r_data;
      w_dv_next    = 1'b0;
      w_fe_next    = 1'b0;
      w_tx_next    = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            w_bit_next = '0;
            // armed means rxs was seen high here, so a low now is a true 1->0 edge
            if (r_armed && !r_rxs) begin
               w_state_next = S_START;
            end else begin
               w_armed_next = r_rxs && w_fill_done;
            end
         end
         S_START: begin
            if (r_cnt == CNT_W'(HALF - 1)) begin
               w_cnt_next   = '0;
               w_state_next = r_rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_cnt_next   = '0;
               w_shift_next = {r_rxs, r_shift[DATA_WIDTH-1:1]};
               if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                  w_bit_next   = '0;
                  w_state_next = S_STOP;
               end else begin
                  w_bit_next = r_bit + BIT_W'(1);
               end
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_cnt_next = '0;
               if (r_rxs) begin
                  w_data_next  = r_shift;
                  w_dv_next    = 1'b1;
                  w_state_next = S_ACK_WAIT;
               end else begin
                  w_fe_next    = 1'b1;
                  w_state_next = S_ERR_WAIT;
               end
            end
         end
         S_ERR_WAIT: begin
            // counts consecutive high samples only
            if (!r_rxs) begin
               w_cnt_next = '0;
            end else if (w_baud_end) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end
         end
         S_ACK_WAIT: begin
            if (r_cnt == CNT_W'(ACK_DELAY)) begin
               w_cnt_next   = '0;
               w_shift_next = ACK_VALUE;
               w_tx_next    = 1'b0;
               w_state_next = S_ACK_START;
            end
         end
         S_ACK_START: begin
            w_tx_next = 1'b0;
            if (w_baud_end) begin
               w_cnt_next   = '0;
               w_tx_next    = r_shift[0];
               w_state_next = S_ACK_DATA;
            end
         end
         S_ACK_DATA: begin
            w_tx_next = r_shift[0];
            if (w_baud_end) begin
               w_cnt_next = '0;
               if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                  w_bit_next   = '0;
                  w_tx_next    = 1'b1;
                  w_state_next = S_ACK_STOP;
               end else begin
                  w_bit_next   = r_bit + BIT_W'(1);
                  w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
                  w_tx_next    = r_shift[1];
               end
            end
         end
         S_ACK_STOP: begin
            if (w_baud_end) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
         end
      endcase

      w_busy_next = (w_state_next != S_IDLE);
   end

   assign tx          = r_tx;
   assign data_out    = r_data;
   assign data_valid  = r_dv;
   assign frame_error = r_fe;
   assign busy        = r_busy;

endmodule

// File: tb/tb_uart_ack_responder.sv
// Self-checking bench for uart_ack_responder: drives UART frames on rx, decodes
// the ACK frames on tx and compares against expectations derived from the frame rules.

module tb_uart_ack_responder;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 230400;
   localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
   localparam int HALF      = BAUD_DIV / 2;
   localparam int DW        = 8;
   localparam int ACK_DELAY = 100;
   localparam logic [7:0] ACK_VALUE = 8'b11001100;
   localparam int ACK_BUDGET = ACK_DELAY + 12 * BAUD_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       tx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   uart_ack_responder #(
      .DATA_WIDTH(DW), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
      .ACK_VALUE(ACK_VALUE), .ACK_DELAY(ACK_DELAY)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .data_out(data_out),
      .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   logic [7:0] dv_q[$];
   int         dv_cyc_q[$];
   int         fe_cnt = 0, both_cnt = 0, tx_low_cnt = 0, last_fall = 0;
   logic       tx_prev = 1'b1;
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_q.push_back(data_out);
         dv_cyc_q.push_back(cyc);
      end
      if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
      if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt <= both_cnt + 1;
      if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
      if (tx_prev === 1'b1 && tx === 1'b0) last_fall <= cyc;
      tx_prev <= tx;
   end

   // ACK frame decoder: mid-bit sampling, then frame length up to busy falling
   logic [7:0] ack_byte_q[$];
   bit         ack_ok_q[$];
   int         ack_fall_q[$];
   int         ack_len_q[$];
   int         d_f, d_n;
   logic [7:0] d_b;
   bit         d_ok;
   initial begin : ack_decoder
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            d_f = cyc;
            d_ok = 1'b1;
            repeat (HALF) @(negedge clk);
            if (tx !== 1'b0) d_ok = 1'b0;
            for (int i = 0; i < DW; i++) begin
               repeat (BAUD_DIV) @(negedge clk);
               d_b[i] = tx;
            end
            repeat (BAUD_DIV) @(negedge clk);
            if (tx !== 1'b1) d_ok = 1'b0;
            d_n = 0;
            while (busy !== 1'b0 && d_n < 3 * BAUD_DIV) begin
               @(negedge clk);
               d_n++;
            end
            ack_byte_q.push_back(d_b);
            ack_ok_q.push_back(d_ok);
            ack_fall_q.push_back(d_f);
            ack_len_q.push_back((busy === 1'b0) ? cyc - d_f : -1);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive start bit, the first nbits data bits LSB first, and the stop bit if complete
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
      rx = 1'b0;
      tick(BAUD_DIV);
      for (int i = 0; i < nbits; i++) begin
         rx = b[i];
         tick(BAUD_DIV);
      end
      if (nbits == DW) begin
         rx = stop;
         tick(BAUD_DIV);
      end
   endtask

   task automatic wait_idle(input int n_ack, input int budget, output bit ok);
      int n = 0;
      while (!(ack_byte_q.size() >= n_ack && busy === 1'b0) && n < budget) begin
         tick(1);
         n++;
      end
      ok = (ack_byte_q.size() >= n_ack && busy === 1'b0);
   endtask

   task automatic test_reset();
      int fe0, dv0;
      rst = 1'b1;
      rx  = 1'b1;
      tick(3);
      total++;
      if ({tx, busy, data_valid, frame_error} !== 4'b1000) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=1000", {tx, busy, data_valid, frame_error});
      end
      total++;
      if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
      // line already low when reset releases must not start a frame
      fe0 = fe_cnt; dv0 = dv_q.size();
      rx = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(300);
      rx = 1'b1;
      tick(20);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL low_at_release_busy got=%b exp=0", busy); end
      total++;
      if (dv_q.size() - dv0 + fe_cnt - fe0 !== 0) begin
         bad++; $display("FAIL low_at_release_events got=%0d exp=0", dv_q.size() - dv0 + fe_cnt - fe0);
      end
   endtask

   task automatic test_basic();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size(), fe0 = fe_cnt;
      bit ok;
      send_frame(8'hA5, 1'b1, DW);
      wait_idle(a0 + 1, ACK_BUDGET, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_done got=timeout exp=idle"); end
      total++;
      if (dv_q.size() - dv0 !== 1) begin bad++; $display("FAIL basic_dv_cycles got=%0d exp=1", dv_q.size() - dv0); end
      total++;
      if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL basic_fe got=%0d exp=0", fe_cnt - fe0); end
      if (dv_q.size() > dv0 && ack_byte_q.size() > a0) begin
         total++;
         if (dv_q[dv0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", dv_q[dv0]); end
         total++;
         if (ack_byte_q[a0] !== ACK_VALUE || !ack_ok_q[a0]) begin
            bad++; $display("FAIL basic_ack got=%h framed=%0d exp=%h framed=1", ack_byte_q[a0], ack_ok_q[a0], ACK_VALUE);
         end
         total++;
         if (ack_fall_q[a0] - dv_cyc_q[dv0] !== ACK_DELAY + 1) begin
            bad++; $display("FAIL basic_gap got=%0d exp=%0d", ack_fall_q[a0] - dv_cyc_q[dv0], ACK_DELAY + 1);
         end
         total++;
         if (ack_len_q[a0] !== (DW + 2) * BAUD_DIV) begin
            bad++; $display("FAIL basic_ack_len got=%0d exp=%0d", ack_len_q[a0], (DW + 2) * BAUD_DIV);
         end
      end
   endtask

   task automatic test_frame_error();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size(), fe0 = fe_cnt, tl0 = tx_low_cnt;
      bit ok;
      send_frame(8'h3C, 1'b0, DW);
      rx = 1'b1;
      wait_idle(a0, 3 * BAUD_DIV, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ferr_recover got=timeout exp=idle"); end
      total++;
      if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
      total++;
      if (dv_q.size() - dv0 !== 0 || tx_low_cnt - tl0 !== 0) begin
         bad++; $display("FAIL ferr_quiet got dv=%0d txlow=%0d exp 0 0", dv_q.size() - dv0, tx_low_cnt - tl0);
      end
      send_frame(8'h0F, 1'b1, DW);
      wait_idle(a0 + 1, ACK_BUDGET, ok);
      total++;
      if (!ok || dv_q.size() - dv0 !== 1) begin
         bad++; $display("FAIL ferr_next_dv got=%0d exp=1", dv_q.size() - dv0);
      end else begin
         total++;
         if (dv_q[dv0] !== 8'h0F || ack_byte_q[a0] !== ACK_VALUE) begin
            bad++; $display("FAIL ferr_next_data got=%h ack=%h exp=0f ack=%h", dv_q[dv0], ack_byte_q[a0], ACK_VALUE);
         end
      end
   endtask

   task automatic test_glitch();
      int dv0 = dv_q.size(), fe0 = fe_cnt, tl0 = tx_low_cnt, n = 0;
      bit saw_busy = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (busy === 1'b1) saw_busy = 1'b1;
      end
      rx = 1'b1;
      while (busy !== 1'b0 && n < 110) begin tick(1); n++; end
      total++;
      if (!saw_busy) begin bad++; $display("FAIL glitch_busy_rise got=0 exp=1"); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_drop got=%b exp=0 after %0d", busy, n); end
      tick(12 * BAUD_DIV);
      total++;
      if (dv_q.size() - dv0 + fe_cnt - fe0 + tx_low_cnt - tl0 !== 0) begin
         bad++; $display("FAIL glitch_quiet got dv=%0d fe=%0d txlow=%0d exp 0", dv_q.size() - dv0, fe_cnt - fe0, tx_low_cnt - tl0);
      end
   endtask

   task automatic test_ignore_during_ack();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size(), fe0 = fe_cnt, n = 0;
      logic [7:0] b = 8'($urandom_range(0, 255));
      bit ok;
      send_frame(b, 1'b1, DW);
      while (tx !== 1'b0 && n < ACK_DELAY + 3 * BAUD_DIV) begin tick(1); n++; end
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL ign_ack_start got=%b exp=0", tx); end
      n = last_fall + 20 - cyc;
      if (n > 0) tick(n);
      send_frame(8'h77, 1'b1, DW);
      wait_idle(a0 + 1, 4 * BAUD_DIV, ok);
      tick(3 * BAUD_DIV);
      total++;
      if (!ok || busy !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b exp=0", busy); end
      total++;
      if (dv_q.size() - dv0 !== 1 || ack_byte_q.size() - a0 !== 1 || fe_cnt - fe0 !== 0) begin
         bad++; $display("FAIL ign_counts got dv=%0d ack=%0d fe=%0d exp 1 1 0", dv_q.size() - dv0, ack_byte_q.size() - a0, fe_cnt - fe0);
      end else begin
         total++;
         if (dv_q[dv0] !== b || ack_byte_q[a0] !== ACK_VALUE || !ack_ok_q[a0]) begin
            bad++; $display("FAIL ign_values got=%h ack=%h exp=%h ack=%h", dv_q[dv0], ack_byte_q[a0], b, ACK_VALUE);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size();
      bit ok;
      send_frame(8'h12, 1'b1, 4);
      tick(HALF);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({tx, busy, data_valid} !== 3'b100 || data_out !== 8'h00) begin
         bad++; $display("FAIL rstmid_abort got tx/busy/dv=%b data=%h exp 100 00", {tx, busy, data_valid}, data_out);
      end
      rx = 1'b1;
      tick(5);
      rst = 1'b0;
      tick(10);
      send_frame(8'h55, 1'b1, DW);
      wait_idle(a0 + 1, ACK_BUDGET, ok);
      total++;
      if (!ok || dv_q.size() - dv0 !== 1) begin
         bad++; $display("FAIL rstmid_dv_count got=%0d exp=1", dv_q.size() - dv0);
      end else begin
         total++;
         if (dv_q[dv0] !== 8'h55 || ack_byte_q[a0] !== ACK_VALUE) begin
            bad++; $display("FAIL rstmid_data got=%h ack=%h exp=55 ack=%h", dv_q[dv0], ack_byte_q[a0], ACK_VALUE);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size();
      bit ok1, ok2;
      send_frame(8'h00, 1'b1, DW);
      wait_idle(a0 + 1, ACK_BUDGET, ok1);
      send_frame(8'hFF, 1'b1, DW);
      wait_idle(a0 + 2, ACK_BUDGET, ok2);
      total++;
      if (!(ok1 && ok2) || dv_q.size() - dv0 !== 2 || ack_byte_q.size() - a0 !== 2) begin
         bad++; $display("FAIL b2b_counts got dv=%0d ack=%0d exp 2 2", dv_q.size() - dv0, ack_byte_q.size() - a0);
      end else begin
         total++;
         if (dv_q[dv0] !== 8'h00 || dv_q[dv0 + 1] !== 8'hFF) begin
            bad++; $display("FAIL b2b_data got=%h,%h exp=00,ff", dv_q[dv0], dv_q[dv0 + 1]);
         end
         for (int k = 0; k < 2; k++) begin
            total++;
            if (ack_byte_q[a0 + k] !== ACK_VALUE || !ack_ok_q[a0 + k] || ack_len_q[a0 + k] !== (DW + 2) * BAUD_DIV) begin
               bad++; $display("FAIL b2b_ack%0d got=%h len=%0d exp=%h len=%0d", k, ack_byte_q[a0 + k], ack_len_q[a0 + k], ACK_VALUE, (DW + 2) * BAUD_DIV);
            end
         end
      end
   endtask

   // Random bytes with occasional bad stop bits; the model lists which bytes must appear
   task automatic test_random();
      int dv0 = dv_q.size(), a0 = ack_byte_q.size(), fe0 = fe_cnt, both0 = both_cnt;
      logic [7:0] exp_dv[$];
      int exp_fe = 0;
      logic [7:0] b;
      bit stop, ok;
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         tick($urandom_range(1, 40));
         send_frame(b, stop, DW);
         if (stop) exp_dv.push_back(b); else exp_fe++;
         rx = 1'b1;
         wait_idle(a0 + exp_dv.size(), ACK_BUDGET, ok);
      end
      total++;
      if (dv_q.size() - dv0 !== exp_dv.size() || ack_byte_q.size() - a0 !== exp_dv.size() || fe_cnt - fe0 !== exp_fe) begin
         bad++; $display("FAIL rnd_counts got dv=%0d ack=%0d fe=%0d exp %0d %0d %0d", dv_q.size() - dv0, ack_byte_q.size() - a0, fe_cnt - fe0, exp_dv.size(), exp_dv.size(), exp_fe);
      end else begin
         for (int k = 0; k < exp_dv.size(); k++) begin
            total++;
            if (dv_q[dv0 + k] !== exp_dv[k] || ack_byte_q[a0 + k] !== ACK_VALUE) begin
               bad++; $display("FAIL rnd_frame%0d got=%h ack=%h exp=%h ack=%h", k, dv_q[dv0 + k], ack_byte_q[a0 + k], exp_dv[k], ACK_VALUE);
            end
         end
      end
      total++;
      if (both_cnt - both0 !== 0) begin bad++; $display("FAIL rnd_dv_fe_overlap got=%0d exp=0", both_cnt - both0); end
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_frame_error();
      test_glitch();
      test_ignore_during_ack();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
